cpu_run_ctrl: RTL and testbench



---
 rtl/cpu_run_ctrl_if.sv | 31 +++
 rtl/cpu_run_ctrl.sv | 163 ++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_run_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_run_ctrl_if
// Brief    : Control/status bundle between board logic and the CPU run
//            controller (switches, button, breakpoint, pc, advance pulse).
// Revision : 1.0 - initial release
// ============================================================================
interface cpu_run_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             run_sw;
    logic             step_btn;
    logic             bkpt_arm;
    logic [WIDTH-1:0] bkpt_addr;
    logic [WIDTH-1:0] pc;
    logic             cpu_en;
    logic [1:0]       state;
    logic             halted;
    logic             tick_led;

    modport master (
        output run_sw, step_btn, bkpt_arm, bkpt_addr, pc,
        input  cpu_en, state, halted, tick_led
    );

    modport slave (
        input  run_sw, step_btn, bkpt_arm, bkpt_addr, pc,
        output cpu_en, state, halted, tick_led
    );
endinterface
`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_run_ctrl
// Brief    : Clock-enable execution controller: programmable-rate run,
//            debounced single step, PC breakpoint halt.
//            Optional macro CPU_RUN_CTRL_BKPT_EN adds breakpoint/BREAK state.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_run_ctrl #(
    parameter int WIDTH      = 8,
    parameter int DIV        = 25000000,
    parameter int DEB_CYCLES = 1000000
) (
    input  wire logic         clk,
    input  wire logic         rst,
    cpu_run_ctrl_if.slave     bus
);

    localparam int c_pre_w = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int c_deb_w = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [c_pre_w-1:0] c_pre_max = c_pre_w'(DIV - 1);
    localparam logic [c_deb_w-1:0] c_deb_max = c_deb_w'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_HALT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STEP  = 2'b10,
        ST_BREAK = 2'b11
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_cpu_en;
    logic                 w_cpu_en_nxt;
    logic [c_pre_w-1:0]   r_pre_cnt;
    logic [c_pre_w-1:0]   w_pre_nxt;
    logic                 r_tick_led;

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_stable;
    logic                 r_stable_d;
    logic [c_deb_w-1:0]   r_deb_cnt;
    logic                 w_step_req;

    logic [WIDTH-1:0]     w_pc;
    logic                 w_hit;

    assign w_pc = bus.pc;

    // Step button: two-flop synchronizer, then accept a new level only after
    // DEB_CYCLES consecutive cycles of disagreement with the accepted level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
            r_deb_cnt  <= '0;
        end else begin
            r_sync1    <= bus.step_btn;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            if (r_sync2 == r_stable) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == c_deb_max) begin
                r_stable  <= r_sync2;
                r_deb_cnt <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + 1'b1;
            end
        end
    end

    assign w_step_req = r_stable & ~r_stable_d;

`ifdef CPU_RUN_CTRL_BKPT_EN
    logic r_mask;

    // The mask drops on the pulse cycle itself, so the pc checked afterwards
    // is already the one the core moved to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask <= 1'b1;
        end else if ((r_state == ST_HALT) && bus.run_sw) begin
            r_mask <= 1'b1;
        end else if ((r_state == ST_RUN) && r_cpu_en) begin
            r_mask <= 1'b0;
        end
    end

    assign w_hit = (r_state == ST_RUN) && bus.bkpt_arm &&
                   (w_pc == bus.bkpt_addr) && !r_mask;
`else
    logic w_unused;

    assign w_hit    = 1'b0;
    assign w_unused = ^{bus.bkpt_arm, bus.bkpt_addr, w_pc};
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_cpu_en_nxt = 1'b0;
        w_pre_nxt    = '0;
        case (r_state)
            ST_HALT: begin
                if (bus.run_sw) begin
                    w_state_nxt = ST_RUN;
                end else if (w_step_req) begin
                    w_state_nxt  = ST_STEP;
                    w_cpu_en_nxt = 1'b1;
                end
            end
            ST_STEP: begin
                w_state_nxt = ST_HALT;
            end
            ST_RUN: begin
                // A hit takes priority over a tick landing on the same edge.
                if (!bus.run_sw) begin
                    w_state_nxt = ST_HALT;
                end else if (w_hit) begin
                    w_state_nxt = ST_BREAK;
                end else if (r_pre_cnt == c_pre_max) begin
                    w_cpu_en_nxt = 1'b1;
                end else begin
                    w_pre_nxt = r_pre_cnt + 1'b1;
                end
            end
            ST_BREAK: begin
                if (!bus.run_sw) begin
                    w_state_nxt = ST_HALT;
                end else if (w_step_req) begin
                    w_state_nxt  = ST_STEP;
                    w_cpu_en_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_HALT;
            r_cpu_en   <= 1'b0;
            r_pre_cnt  <= '0;
            r_tick_led <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cpu_en   <= w_cpu_en_nxt;
            r_pre_cnt  <= w_pre_nxt;
            r_tick_led <= r_tick_led ^ r_cpu_en;
        end
    end

    assign bus.cpu_en   = r_cpu_en;
    assign bus.state    = r_state;
    assign bus.halted   = (r_state != ST_RUN);
    assign bus.tick_led = r_tick_led;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_run_ctrl
// Brief    : Self-checking bench for cpu_run_ctrl (DIV=4, DEB_CYCLES=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_run_ctrl;

    localparam int WIDTH = 8;
    localparam int DIV   = 4;
    localparam int DEB   = 3;
`ifdef CPU_RUN_CTRL_BKPT_EN
    localparam bit BKPT_ON = 1'b1;
`else
    localparam bit BKPT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cpu_run_ctrl_if #(.WIDTH(WIDTH)) bus ();

    cpu_run_ctrl #(
        .WIDTH      (WIDTH),
        .DIV        (DIV),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Stand-in CPU core: pc advances on every enabled edge.
    logic [WIDTH-1:0] pc_q;
    always @(posedge clk) begin
        if (rst)             pc_q <= '0;
        else if (bus.cpu_en) pc_q <= pc_q + 1'b1;
    end
    assign bus.pc = pc_q;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: outputs expected after each edge.
    int  m_state;
    bit  m_en, m_led, m_mask, m_stable, m_req, m_valid;
    int  run_age;
    bit  hist[$];

    always @(posedge clk) begin
        bit hit;
        bit nen;
        bit alld;
        int nst;
        if (rst) begin
            m_state = 0; m_en = 0; m_led = 0; m_mask = 1;
            m_stable = 0; m_req = 0; run_age = 0; m_valid = 1;
            hist.delete();
            for (int i = 0; i < DEB + 2; i++) hist.push_back(1'b0);
        end else begin
            m_led = m_led ^ m_en;
            nen = 0;
            nst = m_state;
            hit = BKPT_ON && bus.bkpt_arm && (bus.pc == bus.bkpt_addr) && !m_mask;
            case (m_state)
                0: if (bus.run_sw) begin nst = 1; run_age = 0; m_mask = 1; end
                   else if (m_req) begin nst = 2; nen = 1; end
                2: nst = 0;
                1: begin
                    if (!bus.run_sw) nst = 0;
                    else if (hit) nst = 3;
                    else begin
                        run_age++;
                        if (run_age % DIV == 0) nen = 1;
                    end
                    if (m_en) m_mask = 0;
                end
                default: if (!bus.run_sw) nst = 0;
                         else if (m_req) begin nst = 2; nen = 1; end
            endcase
            // Debounce: the synchronized level lags the pin by two edges;
            // accept it once the last DEB synchronized samples all disagree.
            hist.push_back(bus.step_btn);
            if (hist.size() > DEB + 4) void'(hist.pop_front());
            alld = 1;
            for (int i = 0; i < DEB; i++)
                if (hist[hist.size() - 3 - i] == m_stable) alld = 0;
            m_req = 0;
            if (alld) begin
                m_stable = ~m_stable;
                m_req    = m_stable;
            end
            m_en    = nen;
            m_state = nst;
        end
    end

    bit prev_en    = 0;
    bit seen_break = 0;
    always @(negedge clk) begin
        if (m_valid) begin
            check("state",    int'(bus.state),    m_state);
            check("cpu_en",   int'(bus.cpu_en),   int'(m_en));
            check("halted",   int'(bus.halted),   int'(m_state != 1));
            check("tick_led", int'(bus.tick_led), int'(m_led));
            check("en_back_to_back", int'(bus.cpu_en & prev_en), 0);
            prev_en = bus.cpu_en;
            if (bus.state == 2'b11) seen_break = 1;
        end
    end

    task automatic run_count(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            cnt += int'(bus.cpu_en);
        end
    endtask

    task automatic wait_state(input int s, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((int'(bus.state) != s) && (n < budget));
        check("wait_state", int'(bus.state), s);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int c;
        int t;
        rst           = 1'b1;
        bus.run_sw    = 1'b0;
        bus.step_btn  = 1'b1;
        bus.bkpt_arm  = 1'b0;
        bus.bkpt_addr = '0;

        // Reset, with the button held throughout
        repeat (2) @(negedge clk);
        check("rst_state", int'(bus.state), 0);
        check("rst_cpu_en", int'(bus.cpu_en), 0);
        rst          = 1'b0;
        bus.step_btn = 1'b0;
        run_count(10, c);
        check("reset_state", int'(bus.state), 0);
        check("reset_halted", int'(bus.halted), 1);
        check("reset_tick_led", int'(bus.tick_led), 0);
        check("reset_no_pulse", c, 0);

        // Continuous run
        bus.run_sw = 1'b1;
        c = 0;
        for (int i = 1; i <= 13; i++) begin
            @(negedge clk);
            c += int'(bus.cpu_en);
            check("run_pulse", int'(bus.cpu_en), int'(i >= 5 && i % 4 == 1));
            if (i == 1) check("run_entry_state", int'(bus.state), 1);
            if (i == 6) check("tick_led_toggle", int'(bus.tick_led), 1);
        end
        check("run_pulse_count", c, 3);
        repeat (2) @(negedge clk);
        bus.run_sw = 1'b0;
        run_count(8, c);
        check("stop_no_pulse", c, 0);
        check("stop_state", int'(bus.state), 0);
        bus.run_sw = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check("rerun_pulse", int'(bus.cpu_en), int'(i == 5));
        end
        bus.run_sw = 1'b0;
        run_count(4, c);

        // Step / debounce
        bus.step_btn = 1'b1;
        repeat (2) @(negedge clk);
        bus.step_btn = 1'b0;
        run_count(12, c);
        check("short_press_no_pulse", c, 0);
        bus.step_btn = 1'b1;
        c = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            c += int'(bus.cpu_en);
            check("step_pulse", int'(bus.cpu_en), int'(i == 6));
            check("step_state", int'(bus.state), (i == 6) ? 2 : 0);
        end
        bus.step_btn = 1'b0;
        run_count(12, t);
        check("step_pulse_count", c + t, 1);

        // Breakpoint run from pc=0
        do_reset();
        bus.bkpt_arm  = 1'b1;
        bus.bkpt_addr = 8'h05;
        bus.run_sw    = 1'b1;
`ifdef CPU_RUN_CTRL_BKPT_EN
        wait_state(3, 60, t);
        check("break_latency", t, 23);
        check("break_pc", int'(pc_q), 5);
        run_count(40, c);
        check("break_no_pulse", c, 0);
        check("break_hold", int'(bus.state), 3);

        // Resume from the breakpoint pc
        bus.run_sw = 1'b0;
        repeat (2) @(negedge clk);
        check("resume_halt", int'(bus.state), 0);
        bus.run_sw = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check("resume_no_break", int'(bus.state), 1);
            check("resume_pulse", int'(bus.cpu_en), int'(i == 5));
        end
        @(negedge clk);
        check("resume_pc", int'(pc_q), 6);
        bus.bkpt_addr = 8'h07;
        wait_state(3, 20, t);
        check("rebreak_latency", t, 5);
        check("rebreak_pc", int'(pc_q), 7);

        // Step off the breakpoint
        bus.step_btn = 1'b1;
        c = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            c += int'(bus.cpu_en);
            check("bstep_pulse", int'(bus.cpu_en), int'(i == 6));
            if (i == 6) check("bstep_state_step", int'(bus.state), 2);
            if (i == 7) check("bstep_state_halt", int'(bus.state), 0);
            if (i == 8) check("bstep_state_run", int'(bus.state), 1);
        end
        bus.step_btn = 1'b0;
        bus.run_sw   = 1'b0;
        run_count(12, t);
        check("bstep_count", c + t, 1);
        check("bstep_pc", int'(pc_q), 8);
`else
        run_count(60, c);
        check("nobkpt_pulses", c, 14);
        check("nobkpt_pc", int'(pc_q), 14);
        check("never_break", int'(seen_break), 0);
        bus.run_sw = 1'b0;
        run_count(4, c);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
